heartbeat_pulse_generator: RTL and testbench

HEARTBEAT_PULSE_GENERATOR -- requirements
Module: heartbeat_pulse_generator

---
 rtl/heartbeat_pulse_generator_if.sv | 25 ++
 rtl/heartbeat_pulse_generator.sv | 161 ++++++++++++++++
 tb/tb_heartbeat_pulse_generator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/heartbeat_pulse_generator_if.sv
// Control and status bundle for the heartbeat pulse generator.
// The master side is the stimulus/configuration owner and the slave side is the generator.
interface heartbeat_pulse_generator_if;
    logic        enable;
    logic [11:0] rr_period_ms;
    logic        cfg_load;
    logic        jitter_en;
    logic        skip_en;
    logic        pulse_out;
    logic        beat_strobe;
    logic        missed_strobe;
    logic [7:0]  beat_count;
    logic [11:0] cfg_active;
    logic        running;

    modport master (
        output enable, rr_period_ms, cfg_load, jitter_en, skip_en,
        input  pulse_out, beat_strobe, missed_strobe, beat_count, cfg_active, running
    );

    modport slave (
        input  enable, rr_period_ms, cfg_load, jitter_en, skip_en,
        output pulse_out, beat_strobe, missed_strobe, beat_count, cfg_active, running
    );
endinterface

// File: rtl/heartbeat_pulse_generator.sv
// Heartbeat pulse generator: a programmable-period pulse train with optional LFSR jitter
// and periodic dropped beats. One clk_div cycle represents 1 ms.
module heartbeat_pulse_generator #(
    parameter int unsigned PULSE_WIDTH_MS = 10,
    parameter int unsigned SKIP_N         = 8,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input logic                        clk_div,
    input logic                        rst_n,
    heartbeat_pulse_generator_if.slave bus
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_HIGH     = 2'd1;
    localparam logic [1:0]  S_LOW      = 2'd2;
    localparam logic [11:0] RST_PERIOD = 12'd1000;
    localparam logic [11:0] MIN_PERIOD = 12'(PULSE_WIDTH_MS + 1);
    localparam logic [11:0] PW_M1      = 12'(PULSE_WIDTH_MS - 1);
    localparam logic [7:0]  IDX_LAST   = 8'(SKIP_N - 1);

    function automatic logic [11:0] clamp_load(input logic [11:0] v);
        return (v < MIN_PERIOD) ? MIN_PERIOD : v;
    endfunction

    // 14 signed bits give headroom for both cfg-8 going negative and 4095+7 overflowing.
    function automatic logic [11:0] sat_period(input logic signed [13:0] v);
        if (v < $signed({2'b00, MIN_PERIOD}))
            return MIN_PERIOD;
        else if (v > 14'sd4095)
            return 12'hFFF;
        else
            return v[11:0];
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] low_rem_q, low_rem_d;
    logic [11:0] pend_q, pend_d;
    logic [11:0] cfg_q, cfg_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        pulse_q, pulse_d;
    logic        strobe_q, strobe_d;
    logic        missed_q, missed_d;
    logic        running_q, running_d;

    logic               start;
    logic               drop;
    logic signed [13:0] jit;
    logic [11:0]        p_new;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_HIGH;
                    start   = 1'b1;
                end
            end
            S_HIGH: begin
                if (!bus.enable)
                    state_d = S_IDLE;
                else if (cnt_q == 12'd0)
                    state_d = S_LOW;
            end
            S_LOW: begin
                if (!bus.enable)
                    state_d = S_IDLE;
                else if (cnt_q == 12'd0) begin
                    state_d = S_HIGH;
                    start   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The beat about to start takes its period from the pending value, not the old cfg_active.
    always_comb begin
        drop  = start && bus.skip_en && (idx_q == IDX_LAST);
        jit   = $signed({2'b00, pend_q}) + $signed({10'd0, lfsr_q[3:0]}) - 14'sd8;
        p_new = bus.jitter_en ? sat_period(jit) : pend_q;
    end

    always_comb begin
        cnt_d      = cnt_q;
        low_rem_d  = low_rem_q;
        cfg_d      = cfg_q;
        idx_d      = idx_q;
        lfsr_d     = lfsr_q;
        beat_cnt_d = beat_cnt_q;
        pulse_d    = 1'b0;
        strobe_d   = 1'b0;
        missed_d   = 1'b0;
        running_d  = (state_d != S_IDLE);
        pend_d     = bus.cfg_load ? clamp_load(bus.rr_period_ms) : pend_q;

        if (start) begin
            cnt_d     = PW_M1;
            low_rem_d = p_new - MIN_PERIOD;
            cfg_d     = pend_q;
            idx_d     = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
            lfsr_d    = lfsr_next(lfsr_q);
            pulse_d   = !drop;
            strobe_d  = !drop;
            missed_d  = drop;
            if (!drop)
                beat_cnt_d = beat_cnt_q + 8'd1;
        end else if (state_q == S_HIGH && state_d == S_LOW) begin
            cnt_d = low_rem_q;
        end else if (state_d != S_IDLE) begin
            cnt_d   = cnt_q - 12'd1;
            pulse_d = (state_d == S_HIGH) && pulse_q;
        end
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 12'd0;
            low_rem_q  <= 12'd0;
            pend_q     <= RST_PERIOD;
            cfg_q      <= RST_PERIOD;
            idx_q      <= 8'd0;
            lfsr_q     <= LFSR_SEED;
            beat_cnt_q <= 8'd0;
            pulse_q    <= 1'b0;
            strobe_q   <= 1'b0;
            missed_q   <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            low_rem_q  <= low_rem_d;
            pend_q     <= pend_d;
            cfg_q      <= cfg_d;
            idx_q      <= idx_d;
            lfsr_q     <= lfsr_d;
            beat_cnt_q <= beat_cnt_d;
            pulse_q    <= pulse_d;
            strobe_q   <= strobe_d;
            missed_q   <= missed_d;
            running_q  <= running_d;
        end
    end

    assign bus.pulse_out     = pulse_q;
    assign bus.beat_strobe   = strobe_q;
    assign bus.missed_strobe = missed_q;
    assign bus.beat_count    = beat_cnt_q;
    assign bus.cfg_active    = cfg_q;
    assign bus.running       = running_q;

endmodule

// File: tb/tb_heartbeat_pulse_generator.sv
// Directed bench for heartbeat_pulse_generator: period, reload, clamp, skip, jitter,
// disable and asynchronous reset behaviour.
module tb_heartbeat_pulse_generator;

    localparam int LIMIT = 2000;

    logic clk_div = 1'b0;
    logic rst_n   = 1'b0;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    heartbeat_pulse_generator_if bus();

    heartbeat_pulse_generator #(
        .PULSE_WIDTH_MS(10),
        .SKIP_N        (8),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk_div(clk_div),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_div = ~clk_div;
    always @(posedge clk_div) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_rise(input string tag, output int t);
        logic last;
        int   n;
        logic found;
        last  = bus.pulse_out;
        n     = 0;
        found = 1'b0;
        while (!found && n < LIMIT) begin
            @(negedge clk_div);
            n++;
            if (bus.pulse_out && !last) found = 1'b1;
            last = bus.pulse_out;
        end
        t = cyc;
        check({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    task automatic measure_high(output int w);
        w = 0;
        while (bus.pulse_out === 1'b1 && w < LIMIT) begin
            w++;
            @(negedge clk_div);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    initial begin
        int t0, t1, t2, t3, t4, t5, w;
        int st, ms, hi, miss_at;
        int r_prev, r_cur, exp_p;
        logic [7:0] lf;

        bus.enable       = 1'b0;
        bus.rr_period_ms = 12'd0;
        bus.cfg_load     = 1'b0;
        bus.jitter_en    = 1'b0;
        bus.skip_en      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_div);
        check("rst_pulse",   32'(bus.pulse_out), 32'd0);
        check("rst_strobe",  32'(bus.beat_strobe), 32'd0);
        check("rst_missed",  32'(bus.missed_strobe), 32'd0);
        check("rst_count",   32'(bus.beat_count), 32'd0);
        check("rst_cfg",     32'(bus.cfg_active), 32'd1000);
        check("rst_running", 32'(bus.running), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_div);
        check("idle_running", 32'(bus.running), 32'd0);

        // Default period of 1000 with 10-cycle pulses
        bus.enable = 1'b1;
        @(negedge clk_div);
        check("b1_pulse",   32'(bus.pulse_out), 32'd1);
        check("b1_strobe",  32'(bus.beat_strobe), 32'd1);
        check("b1_count",   32'(bus.beat_count), 32'd1);
        check("b1_running", 32'(bus.running), 32'd1);
        t0 = cyc;
        measure_high(w);
        check("b1_width", 32'(w), 32'd10);
        check("b1_strobe_low", 32'(bus.beat_strobe), 32'd0);
        wait_rise("b2", t1);
        check("period_1000", 32'(t1 - t0), 32'd1000);
        check("b2_count", 32'(bus.beat_count), 32'd2);

        // Reload 600 mid-beat: takes effect one beat later
        repeat (50) @(negedge clk_div);
        bus.rr_period_ms = 12'd600;
        bus.cfg_load     = 1'b1;
        @(negedge clk_div);
        bus.cfg_load = 1'b0;
        check("cfg_hold_1000", 32'(bus.cfg_active), 32'd1000);
        wait_rise("b3", t2);
        check("period_keep_1000", 32'(t2 - t1), 32'd1000);
        check("cfg_now_600", 32'(bus.cfg_active), 32'd600);
        wait_rise("b4", t3);
        check("period_600", 32'(t3 - t2), 32'd600);

        // Clamp: 5 becomes 11
        repeat (20) @(negedge clk_div);
        bus.rr_period_ms = 12'd5;
        bus.cfg_load     = 1'b1;
        @(negedge clk_div);
        bus.cfg_load = 1'b0;
        wait_rise("b5", t4);
        check("period_keep_600", 32'(t4 - t3), 32'd600);
        check("cfg_clamped", 32'(bus.cfg_active), 32'd11);
        measure_high(w);
        check("clamp_width", 32'(w), 32'd10);
        wait_rise("b6", t5);
        check("period_11", 32'(t5 - t4), 32'd11);
        check("b6_count", 32'(bus.beat_count), 32'd6);

        // Skipping over eight periods of 11: starts with index 6,7,0..5; index 7 dropped
        bus.skip_en = 1'b1;
        st = 0; ms = 0; hi = 0; miss_at = 0;
        for (int n = 1; n <= 88; n++) begin
            @(negedge clk_div);
            if (bus.beat_strobe) st++;
            if (bus.pulse_out) hi++;
            if (bus.missed_strobe) begin
                ms++;
                miss_at = n;
                check("drop_pulse_low", 32'(bus.pulse_out), 32'd0);
            end
        end
        bus.skip_en = 1'b0;
        check("skip_strobes", 32'(st), 32'd7);
        check("skip_missed", 32'(ms), 32'd1);
        check("skip_miss_at", 32'(miss_at), 32'd22);
        check("skip_high_cycles", 32'(hi), 32'd70);
        check("skip_count", 32'(bus.beat_count), 32'd13);

        // Jitter with period 20; 14 beat starts so far
        lf = 8'hA5;
        for (int i = 0; i < 14; i++) lf = lfsr_step(lf);
        bus.rr_period_ms = 12'd20;
        bus.cfg_load     = 1'b1;
        bus.jitter_en    = 1'b1;
        @(negedge clk_div);
        bus.cfg_load = 1'b0;
        wait_rise("j0", r_prev);
        for (int k = 0; k < 5; k++) begin
            exp_p = 20 + int'(lf[3:0]) - 8;
            lf    = lfsr_step(lf);
            wait_rise("jk", r_cur);
            check("jitter_period", 32'(r_cur - r_prev), 32'(exp_p));
            check("jitter_range", 32'((r_cur - r_prev) >= 12 && (r_cur - r_prev) <= 27), 32'd1);
            check("jitter_cfg", 32'(bus.cfg_active), 32'd20);
            r_prev = r_cur;
        end
        bus.jitter_en = 1'b0;

        // Disable mid-HIGH
        @(negedge clk_div);
        check("dis_pre_pulse", 32'(bus.pulse_out), 32'd1);
        bus.enable = 1'b0;
        @(negedge clk_div);
        check("dis_pulse", 32'(bus.pulse_out), 32'd0);
        check("dis_running", 32'(bus.running), 32'd0);
        check("dis_count", 32'(bus.beat_count), 32'd19);
        repeat (5) @(negedge clk_div);
        check("dis_stay_idle", 32'(bus.running), 32'd0);

        // Asynchronous reset mid-HIGH
        bus.enable = 1'b1;
        @(negedge clk_div);
        check("pre_rst_pulse", 32'(bus.pulse_out), 32'd1);
        check("pre_rst_count", 32'(bus.beat_count), 32'd20);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pulse",   32'(bus.pulse_out), 32'd0);
        check("arst_strobe",  32'(bus.beat_strobe), 32'd0);
        check("arst_running", 32'(bus.running), 32'd0);
        check("arst_count",   32'(bus.beat_count), 32'd0);
        check("arst_cfg",     32'(bus.cfg_active), 32'd1000);
        bus.enable = 1'b0;
        @(negedge clk_div);
        rst_n = 1'b1;

        // enable and cfg_load together: first beat keeps the pending 1000
        @(negedge clk_div);
        bus.enable       = 1'b1;
        bus.cfg_load     = 1'b1;
        bus.rr_period_ms = 12'd30;
        @(negedge clk_div);
        bus.cfg_load = 1'b0;
        check("same_cyc_pulse", 32'(bus.pulse_out), 32'd1);
        check("same_cyc_cfg", 32'(bus.cfg_active), 32'd1000);
        t0 = cyc;
        wait_rise("s2", t1);
        check("same_cyc_period", 32'(t1 - t0), 32'd1000);
        check("same_cyc_cfg2", 32'(bus.cfg_active), 32'd30);
        wait_rise("s3", t2);
        check("period_30", 32'(t2 - t1), 32'd30);
        check("final_count", 32'(bus.beat_count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
